// File: rtl/key_session_mem_ctrl_if.sv
// Command/memory/transmit bundle for key_session_mem_ctrl.
//   master : command front-end / datapath side; drives InputKey, ValidCmd, RW, TxDone
//            and observes the controller status and strobes.
//   slave  : the controller itself.
// Clock and reset are kept as plain ports on the controller.
interface key_session_mem_ctrl_if;
    logic InputKey;
    logic ValidCmd;
    logic RW;
    logic TxDone;
    logic Active;
    logic Mode;
    logic Busy;
    logic AccessMem;
    logic RWMem;
    logic SampleData;
    logic TxData;
    logic Locked;
    logic CmdDone;
    logic TxErr;

    modport master (
        output InputKey, ValidCmd, RW, TxDone,
        input  Active, Mode, Busy, AccessMem, RWMem, SampleData, TxData,
               Locked, CmdDone, TxErr
    );

    modport slave (
        input  InputKey, ValidCmd, RW, TxDone,
        output Active, Mode, Busy, AccessMem, RWMem, SampleData, TxData,
               Locked, CmdDone, TxErr
    );
endinterface

// File: rtl/key_session_mem_ctrl.sv
// Key-gated session memory controller.
// A serial key (MSB first, one bit per ValidCmd) opens a session, the next
// strobed bit latches Mode, and each ValidCmd while the session is open runs a
// read or write command of 1 beat (Mode=0) or BURST_LEN beats (Mode=1).
// Wrong keys lead to a timed lock-out; missing TxDone aborts a read with TxErr;
// an idle session closes by itself.
// Ports:
//   Clk   : clock, rising edge
//   Reset : asynchronous, active-high; returns to key entry with all outputs 0
//   bus   : key_session_mem_ctrl_if.slave (command inputs, status/strobe outputs)
// All outputs are registered and decoded from the state being entered.
module key_session_mem_ctrl #(
    parameter int unsigned       KEY_W        = 4,
    parameter logic [KEY_W-1:0]  KEY_VAL      = 4'b1011,
    parameter int unsigned       BURST_LEN    = 4,
    parameter int unsigned       TX_TIMEOUT   = 16,
    parameter int unsigned       MAX_FAIL     = 3,
    parameter int unsigned       LOCK_CYCLES  = 32,
    parameter int unsigned       IDLE_TIMEOUT = 64
) (
    input logic                   Clk,
    input logic                   Reset,
    key_session_mem_ctrl_if.slave bus
);
    localparam int unsigned T_A  = (LOCK_CYCLES > TX_TIMEOUT) ? LOCK_CYCLES : TX_TIMEOUT;
    localparam int unsigned TMAX = (T_A > IDLE_TIMEOUT) ? T_A : IDLE_TIMEOUT;
    localparam int unsigned TW   = $clog2(TMAX + 1);
    localparam int unsigned BCW  = $clog2(KEY_W + 1);
    localparam int unsigned FW   = $clog2(MAX_FAIL + 1);
    localparam int unsigned BW   = $clog2(BURST_LEN + 1);

    typedef enum logic [2:0] {
        S_KEY, S_LOCKED, S_MODE, S_ACTIVE, S_SAMPLE, S_ACCESS, S_TX
    } state_t;

    state_t           state, state_n;
    logic [KEY_W-1:0] key_sr, key_sr_n, key_shift;
    logic [BCW-1:0]   bit_cnt, bit_cnt_n;
    logic [FW-1:0]    fail_cnt, fail_cnt_n;
    logic [TW-1:0]    timer, timer_n;  // lock-out, TX wait and idle share one timer
    logic [BW-1:0]    beat, beat_n;
    logic             rw_lat, rw_n;
    logic             mode_q, mode_n;
    logic             cmd_done_n, tx_err_n, beat_end;
    logic             busy_n;

    // Keep only the newest KEY_W bits of the serial key.
    assign key_shift = KEY_W'({key_sr, bus.InputKey});
    assign busy_n    = (state_n == S_SAMPLE) || (state_n == S_ACCESS) || (state_n == S_TX);
    assign bus.Mode  = mode_q;

    always_comb begin
        state_n    = state;
        key_sr_n   = key_sr;
        bit_cnt_n  = bit_cnt;
        fail_cnt_n = fail_cnt;
        timer_n    = timer;
        beat_n     = beat;
        rw_n       = rw_lat;
        mode_n     = mode_q;
        cmd_done_n = 1'b0;
        tx_err_n   = 1'b0;
        beat_end   = 1'b0;
        case (state)
            S_KEY: begin
                if (bus.ValidCmd) begin
                    key_sr_n = key_shift;
                    if (bit_cnt == BCW'(KEY_W - 1)) begin
                        bit_cnt_n = '0;
                        if (key_shift == KEY_VAL) begin
                            state_n    = S_MODE;
                            fail_cnt_n = '0;
                        end else if (fail_cnt == FW'(MAX_FAIL - 1)) begin
                            state_n    = S_LOCKED;
                            fail_cnt_n = FW'(MAX_FAIL);
                            timer_n    = '0;
                        end else begin
                            fail_cnt_n = fail_cnt + FW'(1);
                        end
                    end else begin
                        bit_cnt_n = bit_cnt + BCW'(1);
                    end
                end
            end
            S_LOCKED: begin
                if (timer == TW'(LOCK_CYCLES - 1)) begin
                    state_n    = S_KEY;
                    fail_cnt_n = '0;
                    timer_n    = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_MODE: begin
                if (bus.ValidCmd) begin
                    mode_n  = bus.InputKey;
                    state_n = S_ACTIVE;
                    timer_n = '0;
                end
            end
            S_ACTIVE: begin
                if (bus.ValidCmd) begin
                    beat_n  = '0;
                    rw_n    = bus.RW;
                    timer_n = '0;
                    state_n = bus.RW ? S_ACCESS : S_SAMPLE;
                end else if (timer == TW'(IDLE_TIMEOUT - 1)) begin
                    state_n = S_KEY;
                    mode_n  = 1'b0;
                    timer_n = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            S_SAMPLE: state_n = S_ACCESS;
            S_ACCESS: begin
                if (rw_lat) begin
                    state_n = S_TX;
                    timer_n = '0;
                end else begin
                    beat_end = 1'b1;
                end
            end
            S_TX: begin
                // TxDone on the last allowed cycle still completes the beat.
                if (bus.TxDone) begin
                    beat_end = 1'b1;
                end else if (timer == TW'(TX_TIMEOUT - 1)) begin
                    state_n  = S_ACTIVE;
                    tx_err_n = 1'b1;
                    timer_n  = '0;
                end else begin
                    timer_n = timer + TW'(1);
                end
            end
            default: state_n = S_KEY;
        endcase

        if (beat_end) begin
            timer_n = '0;
            if (mode_q && (beat != BW'(BURST_LEN - 1))) begin
                beat_n  = beat + BW'(1);
                state_n = rw_lat ? S_ACCESS : S_SAMPLE;
            end else begin
                state_n    = S_ACTIVE;
                cmd_done_n = 1'b1;
            end
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state          <= S_KEY;
            key_sr         <= '0;
            bit_cnt        <= '0;
            fail_cnt       <= '0;
            timer          <= '0;
            beat           <= '0;
            rw_lat         <= 1'b0;
            mode_q         <= 1'b0;
            bus.Active     <= 1'b0;
            bus.Busy       <= 1'b0;
            bus.AccessMem  <= 1'b0;
            bus.RWMem      <= 1'b0;
            bus.SampleData <= 1'b0;
            bus.TxData     <= 1'b0;
            bus.Locked     <= 1'b0;
            bus.CmdDone    <= 1'b0;
            bus.TxErr      <= 1'b0;
        end else begin
            state          <= state_n;
            key_sr         <= key_sr_n;
            bit_cnt        <= bit_cnt_n;
            fail_cnt       <= fail_cnt_n;
            timer          <= timer_n;
            beat           <= beat_n;
            rw_lat         <= rw_n;
            mode_q         <= mode_n;
            bus.Active     <= (state_n == S_ACTIVE) || busy_n;
            bus.Busy       <= busy_n;
            bus.AccessMem  <= (state_n == S_ACCESS);
            bus.RWMem      <= (state_n == S_ACCESS) && rw_n;
            bus.SampleData <= (state_n == S_SAMPLE);
            bus.TxData     <= (state_n == S_TX);
            bus.Locked     <= (state_n == S_LOCKED);
            bus.CmdDone    <= cmd_done_n;
            bus.TxErr      <= tx_err_n;
        end
    end
endmodule
